packet_generator: RTL and testbench

Parametrised AXI-Stream test-traffic source driving the transmit side of the UDP/Ethernet datapath. Emits a programmed number of fixed-length packets with a selectable payload pattern and an optional inter-packet idle gap. Supports restart and graceful stop at packet boundaries, and reports progress for host-side checking.

---
 rtl/packet_generator.sv | 196 +++++++++++++++++++
 tb/tb_packet_generator.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_generator.sv
// AXI-Stream test-traffic source: emits a programmed number of fixed-length packets
// with a selectable payload pattern, optional inter-packet gap, restart and graceful stop.
module packet_generator #(
  parameter int DATA_WIDTH  = 512,
  parameter int LEN_WIDTH   = 8,
  parameter int DEFAULT_LEN = 4,
  parameter int GAP_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [63:0]             packet_count,
  input  logic [LEN_WIDTH-1:0]    packet_length,
  input  logic [GAP_WIDTH-1:0]    gap_cycles,
  input  logic [1:0]              mode,
  input  logic                    start,
  input  logic                    stop,
  output logic                    busy,
  output logic [63:0]             packets_sent,
  output logic [DATA_WIDTH-1:0]   AXIS_TX_TDATA,
  output logic [DATA_WIDTH/8-1:0] AXIS_TX_TKEEP,
  output logic                    AXIS_TX_TVALID,
  output logic                    AXIS_TX_TLAST,
  input  logic                    AXIS_TX_TREADY
);
  localparam int LANES = DATA_WIDTH / 64;
  localparam logic [31:0] LFSR_SEED = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state_reg, state_next;

  logic                 pending_reg;
  logic                 stop_armed_reg;
  logic [LEN_WIDTH-1:0] len_reg;
  logic [LEN_WIDTH-1:0] beat_idx_reg;
  logic [GAP_WIDTH-1:0] gap_reg;
  logic [GAP_WIDTH-1:0] gap_cnt_reg;
  logic [1:0]           mode_reg;
  logic [63:0]          remaining_reg;
  logic [63:0]          counter_reg;
  logic [63:0]          packet_num_reg;
  logic [63:0]          packets_sent_reg;
  logic [31:0]          lfsr_reg;

  logic take;
  logic accept;
  logic last_accept;
  logic end_run;
  logic [DATA_WIDTH-1:0] lane_data;

  // A run is launched from IDLE whenever a start request is pending.
  assign take        = (state_reg == IDLE) && pending_reg;
  assign accept      = AXIS_TX_TVALID && AXIS_TX_TREADY;
  assign last_accept = accept && AXIS_TX_TLAST;
  assign end_run     = (remaining_reg == 64'd1) || pending_reg || start || stop || stop_armed_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (pending_reg && (packet_count != 64'd0)) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (last_accept) begin
          if (end_run) begin
            state_next = IDLE;
          end else if (gap_reg != '0) begin
            state_next = GAP;
          end
        end
      end
      GAP: begin
        if (pending_reg || start || stop) begin
          state_next = IDLE;
        end else if (gap_cnt_reg == GAP_WIDTH'(1)) begin
          state_next = SEND;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state_reg != IDLE);
    AXIS_TX_TVALID = (state_reg == SEND);
    AXIS_TX_TLAST  = (state_reg == SEND) && (beat_idx_reg == len_reg);
    AXIS_TX_TKEEP  = '1;
  end

  // stop has priority over start when both arrive together.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending_reg <= 1'b0;
    end else if (stop) begin
      pending_reg <= 1'b0;
    end else if (start) begin
      pending_reg <= 1'b1;
    end else if (take) begin
      pending_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stop_armed_reg <= 1'b0;
    end else if (state_reg != SEND) begin
      stop_armed_reg <= 1'b0;
    end else if (stop) begin
      stop_armed_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      len_reg          <= LEN_WIDTH'(DEFAULT_LEN);
      gap_reg          <= '0;
      mode_reg         <= '0;
      remaining_reg    <= '0;
      counter_reg      <= '0;
      packet_num_reg   <= '0;
      packets_sent_reg <= '0;
      lfsr_reg         <= LFSR_SEED;
      beat_idx_reg     <= LEN_WIDTH'(1);
    end else if (take) begin
      len_reg          <= (packet_length == '0) ? LEN_WIDTH'(DEFAULT_LEN) : packet_length;
      gap_reg          <= gap_cycles;
      mode_reg         <= mode;
      remaining_reg    <= packet_count;
      counter_reg      <= '0;
      packet_num_reg   <= '0;
      packets_sent_reg <= '0;
      lfsr_reg         <= LFSR_SEED;
      beat_idx_reg     <= LEN_WIDTH'(1);
    end else if (accept) begin
      counter_reg <= counter_reg + 64'd1;
      lfsr_reg    <= {lfsr_reg[30:0], lfsr_reg[30] ^ lfsr_reg[27]};
      if (AXIS_TX_TLAST) begin
        beat_idx_reg     <= LEN_WIDTH'(1);
        packet_num_reg   <= packet_num_reg + 64'd1;
        remaining_reg    <= remaining_reg - 64'd1;
        packets_sent_reg <= packets_sent_reg + 64'd1;
      end else begin
        beat_idx_reg <= beat_idx_reg + LEN_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      gap_cnt_reg <= '0;
    end else if ((state_reg == SEND) && (state_next == GAP)) begin
      gap_cnt_reg <= gap_reg;
    end else if (state_reg == GAP) begin
      gap_cnt_reg <= gap_cnt_reg - GAP_WIDTH'(1);
    end
  end

  assign packets_sent = packets_sent_reg;

  // Mode 2 lane map: counter, packet number, then their complements in the top two lanes.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      if (gi == 0) begin : g_cnt
        assign lane_data[gi*64 +: 64] = counter_reg;
      end else if (gi == 1) begin : g_pkt
        assign lane_data[gi*64 +: 64] = packet_num_reg;
      end else if (gi == LANES - 2) begin : g_npkt
        assign lane_data[gi*64 +: 64] = ~packet_num_reg;
      end else if (gi == LANES - 1) begin : g_ncnt
        assign lane_data[gi*64 +: 64] = ~counter_reg;
      end else begin : g_zero
        assign lane_data[gi*64 +: 64] = '0;
      end
    end
  endgenerate

  always_comb begin
    case (mode_reg)
      2'd0:    AXIS_TX_TDATA = {(DATA_WIDTH/8){counter_reg[7:0]}};
      2'd1:    AXIS_TX_TDATA = {LANES{counter_reg}};
      2'd2:    AXIS_TX_TDATA = lane_data;
      default: AXIS_TX_TDATA = {(DATA_WIDTH/32){lfsr_reg}};
    endcase
  end

endmodule

// File: tb/tb_packet_generator.sv
// Self-checking bench for packet_generator: directed runs with randomized TREADY/parameters,
// compared cycle by cycle against a queue of expected beats built from the payload rules.
module tb_packet_generator;
  localparam int DW    = 512;
  localparam int LW    = 8;
  localparam int GW    = 16;
  localparam int LANES = DW / 64;
  localparam logic [31:0] SEED = 32'h7FFF_FFFF;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [63:0]   packet_count = '0;
  logic [LW-1:0] packet_length = '0;
  logic [GW-1:0] gap_cycles = '0;
  logic [1:0]    mode = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          busy;
  logic [63:0]   packets_sent;
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tkeep;
  logic          tvalid;
  logic          tlast;
  logic          tready = 1'b0;

  packet_generator #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW), .DEFAULT_LEN(4), .GAP_WIDTH(GW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .packet_count(packet_count), .packet_length(packet_length),
    .gap_cycles(gap_cycles), .mode(mode), .start(start), .stop(stop),
    .busy(busy), .packets_sent(packets_sent),
    .AXIS_TX_TDATA(tdata), .AXIS_TX_TKEEP(tkeep), .AXIS_TX_TVALID(tvalid),
    .AXIS_TX_TLAST(tlast), .AXIS_TX_TREADY(tready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
    bit            first;
    bit            run_start;
    int            gap_before;
    int            idx;
  } beat_t;

  beat_t       exp_q[$];
  int          next_idx;
  logic [63:0] ps_model;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] prbs_next(input logic [31:0] x);
    return {x[30:0], x[30] ^ x[27]};
  endfunction

  function automatic logic [DW-1:0] payload(input int m, input logic [63:0] c,
                                            input logic [63:0] p, input logic [31:0] lf);
    logic [DW-1:0] d;
    d = '0;
    case (m)
      0: for (int i = 0; i < DW/8; i++) d[i*8 +: 8] = c[7:0];
      1: for (int i = 0; i < LANES; i++) d[i*64 +: 64] = c;
      2: begin
        d[63:0]                  = c;
        d[127:64]                = p;
        d[(LANES-2)*64 +: 64]    = ~p;
        d[(LANES-1)*64 +: 64]    = ~c;
      end
      default: for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = lf;
    endcase
    return d;
  endfunction

  // Expected beats of one whole run: beat n of the run carries counter n, packet n/len.
  task automatic append_run(input logic [63:0] count, input int plen, input int gap, input int m);
    int          len;
    logic [31:0] lf;
    logic [63:0] c;
    beat_t       e;
    len = (plen == 0) ? 4 : plen;
    lf  = SEED;
    c   = '0;
    for (int p = 0; p < int'(count); p++) begin
      for (int b = 0; b < len; b++) begin
        e.data       = payload(m, c, 64'(p), lf);
        e.last       = (b == len - 1);
        e.first      = (b == 0);
        e.run_start  = (p == 0) && (b == 0);
        e.gap_before = (p == 0) ? 1 : gap;
        e.idx        = next_idx;
        next_idx++;
        exp_q.push_back(e);
        c++;
        lf = prbs_next(lf);
      end
    end
  endtask

  task automatic cut_after_current();
    int k;
    k = 0;
    while (!exp_q[k].last) k++;
    while (exp_q.size() > k + 1) void'(exp_q.pop_back());
  endtask

  task automatic run(input logic [63:0] count, input int plen, input int gap, input int m,
                     input bit rand_ready, input int stop_at, input int restart_at,
                     input logic [63:0] r_count, input int r_len, input int r_mode, input bit r_stop);
    int idle;
    int drain;
    int k;
    bit exp_valid;
    bit exp_busy;
    bit rdy;
    bit done;
    bit injected;
    exp_q.delete();
    next_idx = 0;
    idle     = 0;
    drain    = 0;
    done     = 1'b0;
    injected = 1'b0;
    append_run(count, plen, gap, m);
    $display("[TB] run count=%0d len=%0d gap=%0d mode=%0d rand_ready=%0d stop_at=%0d restart_at=%0d",
             count, plen, gap, m, rand_ready, stop_at, restart_at);
    @(negedge clk);
    packet_count  = count;
    packet_length = LW'(plen);
    gap_cycles    = GW'(gap);
    mode          = 2'(m);
    start         = 1'b1;
    tready        = 1'b1;
    for (k = 1; k <= 4000 && !done; k++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      if (k == 2) ps_model = '0;
      if (exp_q.size() == 0) begin
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
      end else if (!exp_q[0].first) begin
        exp_valid = 1'b1;
        exp_busy  = 1'b1;
      end else begin
        exp_valid = (idle == exp_q[0].gap_before);
        exp_busy  = exp_valid || !exp_q[0].run_start;
      end
      if (exp_valid && exp_q[0].run_start) ps_model = '0;
      check("tvalid", DW'(tvalid), DW'(exp_valid));
      check("busy", DW'(busy), DW'(exp_busy));
      check("packets_sent", DW'(packets_sent), DW'(ps_model));
      if (exp_valid && tvalid) begin
        check("tdata", tdata, exp_q[0].data);
        check("tlast", DW'(tlast), DW'(exp_q[0].last));
        check("tkeep", DW'(tkeep), DW'({(DW/8){1'b1}}));
        if (!injected && exp_q[0].idx == stop_at) begin
          injected = 1'b1;
          stop = 1'b1;
          cut_after_current();
        end
        if (!injected && exp_q[0].idx == restart_at) begin
          injected      = 1'b1;
          start         = 1'b1;
          stop          = r_stop;
          packet_count  = r_count;
          packet_length = LW'(r_len);
          mode          = 2'(r_mode);
          cut_after_current();
          if (!r_stop) append_run(r_count, r_len, gap, r_mode);
        end
      end
      rdy    = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tready = rdy;
      if (exp_valid && rdy) begin
        if (exp_q[0].last) begin
          ps_model++;
          idle = 0;
        end
        void'(exp_q.pop_front());
      end else if (!exp_valid) begin
        idle++;
      end
      if (exp_q.size() == 0) begin
        drain++;
        if (drain > 4) done = 1'b1;
      end
    end
    check("run_drained", DW'(done), DW'(1'b1));
  endtask

  initial begin
    ps_model = '0;
    resetn   = 1'b0;
    tready   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tvalid", DW'(tvalid), '0);
    check("reset_busy", DW'(busy), '0);
    check("reset_packets_sent", DW'(packets_sent), '0);
    check("reset_tdata", tdata, '0);
    check("reset_tlast", DW'(tlast), '0);
    check("reset_tkeep", DW'(tkeep), DW'({(DW/8){1'b1}}));
    resetn = 1'b1;

    run(3, 0, 0, 0, 1'b0, -1, -1, 0, 0, 0, 1'b0);
    run(2, 2, 5, 2, 1'b1, -1, -1, 0, 0, 0, 1'b0);
    run(1, 3, 0, 3, 1'b1, -1, -1, 0, 0, 0, 1'b0);
    run(1, 3, 0, 3, 1'b0, -1, -1, 0, 0, 0, 1'b0);
    run(10, 4, 0, 0, 1'b0, 1, -1, 0, 0, 0, 1'b0);
    check("stop_packets_sent", DW'(packets_sent), DW'(64'd1));
    run(5, 4, 0, 1, 1'b1, -1, 1, 2, 2, 0, 1'b0);
    run(5, 3, 2, 2, 1'b1, -1, 1, 3, 2, 0, 1'b1);
    run(0, 4, 0, 0, 1'b1, -1, -1, 0, 0, 0, 1'b0);
    run(2, 200, 1, 0, 1'b0, -1, -1, 0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run($urandom_range(1, 4), $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3),
          1'b1, -1, -1, 0, 0, 0, 1'b0);
    end

    $display("[TB] run reset mid-packet");
    @(negedge clk);
    packet_count  = 64'd5;
    packet_length = LW'(4);
    gap_cycles    = '0;
    mode          = 2'd1;
    start         = 1'b1;
    tready        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_tvalid", DW'(tvalid), DW'(1'b1));
    check("pre_reset_tlast", DW'(tlast), '0);
    resetn = 1'b0;
    @(negedge clk);
    check("post_reset_tvalid", DW'(tvalid), '0);
    check("post_reset_tlast", DW'(tlast), '0);
    check("post_reset_busy", DW'(busy), '0);
    check("post_reset_packets_sent", DW'(packets_sent), '0);
    check("post_reset_tdata", tdata, '0);
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_after_reset_tvalid", DW'(tvalid), '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
